// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Op, cause and handler-mode encodings used by decode, the sequencer and the bench.
package pc_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    BEQ,
    BNE,
    BLEZ,
    BGTZ,
    BGEZ,
    BLTZ,
    J,
    JAL,
    JR,
    JALR
  } pc_op_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_EXT,
    CAUSE_BADADDR
  } pc_cause_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC_DEFAULT   = 32'h0000_0180;

  function automatic logic is_reg_jump(input pc_op_t op);
    return (op == JR) || (op == JALR);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-to-fetch bundle of the PC sequencer: decoded control-flow inputs and PC state outputs.
// master = decode/fetch side, slave = the sequencer itself.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int PC_W = 32
) ();

  logic            stall;
  pc_op_t          op;
  logic [PC_W-1:0] rs_data;
  logic [PC_W-1:0] rt_data;
  logic [15:0]     imm;
  logic [25:0]     address;
  logic            exc_req;
  logic            eret;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link_addr;
  logic            taken;
  logic [PC_W-1:0] epc;
  logic            in_exc;
  pc_cause_t       cause;

  modport master (
    output stall, op, rs_data, rt_data, imm, address, exc_req, eret,
    input  pc, link_addr, taken, epc, in_exc, cause
  );

  modport slave (
    input  stall, op, rs_data, rt_data, imm, address, exc_req, eret,
    output pc, link_addr, taken, epc, in_exc, cause
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC target: sequential, branch, jump and register targets plus taken/misalign.
// Zero latency; no flow control.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  pc_op_t          op,
  input  logic [PC_W-1:0] rs_data,
  input  logic [PC_W-1:0] rt_data,
  input  logic [15:0]     imm,
  input  logic [25:0]     address,
  output logic [PC_W-1:0] seq,
  output logic [PC_W-1:0] tgt,
  output logic            taken,
  output logic            misalign
);

  logic [PC_W-1:0] boff;
  logic [PC_W-1:0] btgt;
  logic [PC_W-1:0] jtgt;
  logic            rs_neg;
  logic            rs_zero;
  logic            br_cond;
  logic            is_branch;

  assign seq  = pc + PC_W'(4);
  assign boff = {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign btgt = seq + boff;

  // J-type keeps the upper region bits of the delay-slot address.
  generate
    if (PC_W > 28) begin : g_jtgt_region
      assign jtgt = {seq[PC_W-1:28], address, 2'b00};
    end else begin : g_jtgt_flat
      assign jtgt = {address, 2'b00};
    end
  endgenerate

  assign rs_neg  = rs_data[PC_W-1];
  assign rs_zero = (rs_data == '0);

  always_comb begin
    br_cond   = 1'b0;
    is_branch = 1'b0;
    case (op)
      BEQ:  begin is_branch = 1'b1; br_cond = (rs_data == rt_data); end
      BNE:  begin is_branch = 1'b1; br_cond = (rs_data != rt_data); end
      BLEZ: begin is_branch = 1'b1; br_cond = rs_neg | rs_zero;     end
      BGTZ: begin is_branch = 1'b1; br_cond = ~rs_neg & ~rs_zero;   end
      BGEZ: begin is_branch = 1'b1; br_cond = ~rs_neg;              end
      BLTZ: begin is_branch = 1'b1; br_cond = rs_neg;               end
      default: begin is_branch = 1'b0; br_cond = 1'b0; end
    endcase
  end

  always_comb begin
    taken = 1'b0;
    tgt   = seq;
    if (is_branch) begin
      taken = br_cond;
      if (br_cond) tgt = btgt;
    end else begin
      case (op)
        J, JAL:   begin taken = 1'b1; tgt = jtgt;    end
        JR, JALR: begin taken = 1'b1; tgt = rs_data; end
        default:  begin taken = 1'b0; tgt = seq;     end
      endcase
    end
  end

  assign misalign = is_reg_jump(op) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC with branch/jump resolution, stall hold, exception redirect with EPC capture and ERET.
// Redirects appear on pc one cycle after op; stall holds pc but never blocks exceptions or eret.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC_DEFAULT,
  parameter logic [31:0] EXC_VEC   = PC_EXC_VEC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VEC);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  pc_cause_t       cause_q, cause_d;

  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] tgt;
  logic            taken;
  logic            misalign;
  logic            exc_take;

  pc_target_calc #(
    .PC_W (PC_W)
  ) u_target_calc (
    .pc       (pc_q),
    .op       (bus.op),
    .rs_data  (bus.rs_data),
    .rt_data  (bus.rt_data),
    .imm      (bus.imm),
    .address  (bus.address),
    .seq      (seq),
    .tgt      (tgt),
    .taken    (taken),
    .misalign (misalign)
  );

  // Exceptions are masked while in the handler; the op then proceeds normally.
  assign exc_take = (state_q == ST_RUN) && (bus.exc_req || misalign);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    if (exc_take) begin
      state_d = ST_EXC;
      pc_d    = EXC_PC;
      epc_d   = pc_q;
      cause_d = bus.exc_req ? CAUSE_EXT : CAUSE_BADADDR;
    end else if (bus.eret && (state_q == ST_EXC)) begin
      state_d = ST_RUN;
      pc_d    = epc_q;
    end else if (!bus.stall) begin
      pc_d    = tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RST_PC;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.link_addr = seq;
  assign bus.taken     = taken;
  assign bus.epc       = epc_q;
  assign bus.in_exc    = (state_q == ST_EXC);
  assign bus.cause     = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against an arithmetic reference model.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // reference state
  logic [31:0] m_pc, m_epc;
  logic        m_in_exc;
  int          m_cause;

  pc_sequencer_if #(.PC_W(32)) bus ();

  pc_sequencer #(
    .PC_W      (32),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0180)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_in_exc = 1'b0; m_cause = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},     bus.pc,            m_pc);
    check({tag, ".epc"},    bus.epc,           m_epc);
    check({tag, ".in_exc"}, 32'(bus.in_exc),   32'(m_in_exc));
    check({tag, ".cause"},  32'(bus.cause),    32'(m_cause));
  endtask

  // One decode cycle: drive, check combinational outputs, clock, check registered state.
  task automatic step(input string tag, input int op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, input logic [25:0] addr,
                      input logic st, input logic ex, input logic er);
    logic [31:0] seq, tgt, btgt, jtgt;
    int          rs_s, imm_s;
    bit          tk, bad;
    logic [3:0]  opc;
    opc = op[3:0];
    bus.op = pc_op_t'(opc);
    bus.rs_data = rs; bus.rt_data = rt; bus.imm = imm; bus.address = addr;
    bus.stall = st; bus.exc_req = ex; bus.eret = er;
    #1;
    rs_s  = int'(rs);
    imm_s = int'({{16{imm[15]}}, imm});
    seq   = m_pc + 32'd4;
    btgt  = seq + 32'(imm_s * 4);
    jtgt  = (seq & 32'hF000_0000) | (32'(addr) * 4);
    case (op)
      BEQ:  tk = (rs == rt);
      BNE:  tk = (rs != rt);
      BLEZ: tk = (rs_s <= 0);
      BGTZ: tk = (rs_s > 0);
      BGEZ: tk = (rs_s >= 0);
      BLTZ: tk = (rs_s < 0);
      J, JAL, JR, JALR: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (op == J || op == JAL)        tgt = jtgt;
    else if (op == JR || op == JALR) tgt = rs;
    else if (tk)                     tgt = btgt;
    else                             tgt = seq;
    bad = (op == JR || op == JALR) && (rs % 4 != 0);
    check({tag, ".taken"}, 32'(bus.taken), 32'(tk));
    check({tag, ".link"},  bus.link_addr,  seq);
    if ((ex || bad) && !m_in_exc) begin
      m_epc = m_pc; m_pc = 32'h180; m_in_exc = 1'b1; m_cause = ex ? 1 : 2;
    end else if (er && m_in_exc) begin
      m_pc = m_epc; m_in_exc = 1'b0;
    end else if (!st) begin
      m_pc = tgt;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic nop(input string tag);
    step(tag, OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jr(input string tag, input logic [31:0] dst);
    step(tag, JR, dst, 32'h0, 16'h0, 26'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rs, rt;
    int          op, sel;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.op = OP_NONE; bus.rs_data = '0; bus.rt_data = '0;
    bus.imm = '0; bus.address = '0; bus.exc_req = 1'b0; bus.eret = 1'b0;
    model_reset();
    #12;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.pc", bus.pc, 32'h0);

    nop("seq0"); check("seq0.k", bus.pc, 32'h4);
    nop("seq1"); check("seq1.k", bus.pc, 32'h8);
    nop("seq2"); check("seq2.k", bus.pc, 32'hC);

    jr("to100a", 32'h100);
    step("beq_t", BEQ, 32'd5, 32'd5, 16'hFFFE, 26'h0, 1'b0, 1'b0, 1'b0);
    check("beq_t.k", bus.pc, 32'hFC);
    jr("to100b", 32'h100);
    step("beq_n", BEQ, 32'd5, 32'd6, 16'hFFFE, 26'h0, 1'b0, 1'b0, 1'b0);
    check("beq_n.k", bus.pc, 32'h104);

    jr("to40a", 32'h40);
    step("blez", BLEZ, 32'hFFFF_FFFF, 32'h0, 16'd3, 26'h0, 1'b0, 1'b0, 1'b0);
    check("blez.k", bus.pc, 32'h50);
    jr("to40b", 32'h40);
    step("bgtz", BGTZ, 32'hFFFF_FFFF, 32'h0, 16'd3, 26'h0, 1'b0, 1'b0, 1'b0);
    check("bgtz.k", bus.pc, 32'h44);

    jr("to1000", 32'h1000_0000);
    bus.op = JAL; bus.address = 26'h40;
    #1;
    check("jal.link.k", bus.link_addr, 32'h1000_0004);
    step("jal", JAL, 32'h0, 32'h0, 16'h0, 26'h000_0040, 1'b0, 1'b0, 1'b0);
    check("jal.k", bus.pc, 32'h1000_0100);
    jr("jr_bad", 32'h2002);
    check("jr_bad.pc.k", bus.pc, 32'h180);
    check("jr_bad.epc.k", bus.epc, 32'h1000_0100);
    check("jr_bad.cause.k", 32'(bus.cause), 32'(CAUSE_BADADDR));
    step("eret0", OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0, 1'b0, 1'b1);
    check("eret0.k", bus.pc, 32'h1000_0100);

    jr("to20", 32'h20);
    step("stall_exc", OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1'b1, 1'b0);
    check("stall_exc.pc.k", bus.pc, 32'h180);
    check("stall_exc.epc.k", bus.epc, 32'h20);
    nop("h0");
    step("masked", OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0, 1'b1, 1'b0);
    check("masked.pc.k", bus.pc, 32'h188);
    check("masked.cause.k", 32'(bus.cause), 32'(CAUSE_EXT));
    step("eret1", OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0, 1'b0, 1'b1);
    check("eret1.pc.k", bus.pc, 32'h20);
    check("eret1.in_exc.k", 32'(bus.in_exc), 32'h0);

    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       rs = $urandom & 32'h0000_0FFC;
      else if (sel < 6)  rs = ($urandom & 32'h0000_0FFC) | 32'(1 + $urandom_range(0, 2));
      else               rs = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      step("rand", op, rs, rt, 16'($urandom), 26'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0));
    end

    if (m_in_exc)
      step("pre_eret", OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0, 1'b0, 1'b1);
    step("pre_exc", OP_NONE, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0, 1'b1, 1'b0);
    check("pre_exc.pc.k", bus.pc, 32'h180);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.pc", bus.pc, 32'h0);
    check("arst.in_exc", 32'(bus.in_exc), 32'h0);
    check("arst.epc", bus.epc, 32'h0);
    check("arst.cause", 32'(bus.cause), 32'(CAUSE_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    nop("post0");
    nop("post1");
    check("post1.k", bus.pc, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
